// File: rtl/nonce_collector.sv
// rtl/nonce_collector.sv - show-ahead FIFO capturing miner nonces with drop/hit counters
// Optional duplicate suppression of back-to-back accepted nonces: NONCE_COLLECTOR_DEDUP_EN
module nonce_collector #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       found_in,
    input  logic [31:0]                nonce_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_nonce,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic [31:0]                hit_total
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    logic          push_req;
    logic          pop;
    logic          full;
    logic          dup;
    logic          accept;
    logic          drop;
    logic [AW:0]   rd_next;
    logic [LW-1:0] level_after_pop;
    logic [LW-1:0] level_next;
    logic          bypass;
    logic [31:0]   head_next;

`ifdef NONCE_COLLECTOR_DEDUP_EN
    logic [31:0]   last_accepted;
    logic          last_valid;

    assign dup = last_valid && (nonce_in == last_accepted);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            last_accepted <= 32'd0;
            last_valid    <= 1'b0;
        end else if (accept) begin
            last_accepted <= nonce_in;
            last_valid    <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        push_req        = found_in & ~reset & ~clear;
        pop             = out_valid & out_ready;
        full            = (level == LW'(DEPTH));
        // a pop in the same cycle frees the slot the push needs
        accept          = push_req & ~dup & (~full | pop);
        drop            = push_req & ~dup & full & ~pop;
        rd_next         = rd_ptr + {{AW{1'b0}}, pop};
        level_after_pop = level - {{AW{1'b0}}, pop};
        level_next      = level_after_pop + {{AW{1'b0}}, accept};
        // head becomes the entry being written now when nothing else remains
        bypass          = accept && (level_after_pop == '0);
        head_next       = bypass ? nonce_in : mem[rd_next[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= nonce_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_nonce <= 32'd0;
            drop_cnt  <= '0;
            hit_total <= 32'd0;
        end else begin
            wr_ptr    <= wr_ptr + {{AW{1'b0}}, accept};
            rd_ptr    <= rd_next;
            level     <= level_next;
            out_valid <= (level_next != '0);
            if (level_next != '0) begin
                out_nonce <= head_next;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
            if (accept) begin
                hit_total <= hit_total + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_nonce_collector.sv
// tb/tb_nonce_collector.sv - scoreboard bench for nonce_collector against a queue model
module tb_nonce_collector;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   clear;
    logic                   found_in;
    logic [31:0]            nonce_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_nonce;
    logic [$clog2(DEPTH):0] level;
    logic [DROP_W-1:0]      drop_cnt;
    logic [31:0]            hit_total;

    nonce_collector #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .found_in(found_in), .nonce_in(nonce_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_nonce(out_nonce),
        .level(level), .drop_cnt(drop_cnt), .hit_total(hit_total)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: FIFO as a queue, counters as plain integers
    logic [31:0] mq[$];
    logic [31:0] sb_q[$];
    int unsigned m_drop = 0;
    logic [31:0] m_hit = 0;
    logic [31:0] m_last_out = 0;
    logic [31:0] m_last_acc = 0;
    bit          m_last_ok = 0;
    bit          armed = 0;

    always @(posedge clk) begin
        if (reset || clear) begin
            mq.delete();
            sb_q.delete();
            m_drop = 0;
            m_hit = 0;
            m_last_out = 0;
            m_last_ok = 0;
            armed = 1;
        end else begin
            bit is_dup;
            if (mq.size() > 0 && out_ready) m_last_out = mq.pop_front();
            is_dup = 0;
`ifdef NONCE_COLLECTOR_DEDUP_EN
            is_dup = m_last_ok && (nonce_in == m_last_acc);
`endif
            if (found_in && !is_dup) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(nonce_in);
                    sb_q.push_back(nonce_in);
                    m_hit = m_hit + 1;
                    m_last_acc = nonce_in;
                    m_last_ok = 1;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
        end
    end

    // monitor: compares state every cycle and pops the scoreboard on each handshake
    always @(negedge clk) begin
        if (armed) begin
            chk("level", 32'(level), 32'(mq.size()));
            chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("drop_cnt", 32'(drop_cnt), m_drop);
            chk("hit_total", hit_total, m_hit);
            if (mq.size() > 0) chk("head", out_nonce, mq[0]);
            else               chk("idle_nonce", out_nonce, m_last_out);
            if (out_valid && out_ready && !reset && !clear) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got 0x%08h expected no entry", out_nonce);
                end else begin
                    chk("pop_order", out_nonce, sb_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic f, input logic [31:0] n, input logic r, input logic c);
        found_in  = f;
        nonce_in  = n;
        out_ready = r;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, r, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        found_in = 1'b0;
        nonce_in = 32'd0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("reset_level", 32'(level), 32'd0);

        drive(1'b1, 32'h0000ABCD, 1'b0, 1'b0);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_nonce", out_nonce, 32'h0000ABCD);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("single_popped", 32'(out_valid), 32'd0);

        drive(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 32'h10 + i, 1'b0, 1'b0);
        chk("burst_level", 32'(level), 32'd8);
        chk("burst_drop", 32'(drop_cnt), 32'd2);
        chk("burst_hit", hit_total, 32'd8);
        idle(10, 1'b1);

        drive(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b1, 32'h20 + i, 1'b0, 1'b0);
        drive(1'b1, 32'h99, 1'b1, 1'b0);
        chk("fullpp_level", 32'(level), 32'd8);
        chk("fullpp_drop", 32'(drop_cnt), 32'd0);
        idle(10, 1'b1);

        drive(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) drive(1'b1, 32'h30 + i, 1'b0, 1'b0);
        idle(5, 1'b1);
        chk("mid_level", 32'(level), 32'd3);
        drive(1'b1, 32'h55, 1'b0, 1'b1);
        chk("clear_valid", 32'(out_valid), 32'd0);
        chk("clear_drop", 32'(drop_cnt), 32'd0);
        chk("clear_hit", hit_total, 32'd0);
        chk("clear_nonce", out_nonce, 32'd0);
        idle(2, 1'b1);

        drive(1'b0, 32'd0, 1'b0, 1'b1);
        drive(1'b1, 32'h42, 1'b0, 1'b0);
        drive(1'b1, 32'h42, 1'b0, 1'b0);
        drive(1'b1, 32'h43, 1'b0, 1'b0);
        drive(1'b1, 32'h42, 1'b0, 1'b0);
`ifdef NONCE_COLLECTOR_DEDUP_EN
        chk("dedup_hit", hit_total, 32'd3);
`else
        chk("dedup_hit", hit_total, 32'd4);
`endif
        chk("dedup_drop", 32'(drop_cnt), 32'd0);
        idle(6, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 5)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 199) == 0));
        end
        reset = 1'b1;
        drive(1'b1, 32'h77, 1'b1, 1'b0);
        reset = 1'b0;
        chk("reset_mid", 32'(level), 32'd0);

        for (int i = 0; i < 8; i++) drive(1'b1, 32'h100 + i, 1'b0, 1'b0);
        for (int i = 0; i < 65539; i++) drive(1'b1, 32'h200 + i, 1'b0, 1'b0);
        chk("sat_drop", 32'(drop_cnt), 32'h0000FFFF);
        idle(10, 1'b1);
        chk("sat_hold", 32'(drop_cnt), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
